// File: rtl/fifo_param_scan.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_param_scan
//  Description : Parametrised push-button FIFO with occupancy count,
//                almost-full/almost-empty flags, sticky overflow/underflow
//                flags, an output-valid strobe and an 8-digit multiplexed
//                7-segment view of the queued entries (oldest on digit 0).
//  Ports       : clock, reset        - system clock, synchronous active-high reset
//                en_in, en_out       - push / pop requests (edge or level, see EDGE)
//                in                  - push data
//                clear_err           - clears overflow/underflow
//                out, out_valid      - last popped entry and its 1-cycle strobe
//                empty, full         - count==0 / count==DEPTH
//                almost_empty/full   - count<=AE_LEVEL / count>=AF_LEVEL
//                count               - occupancy 0..DEPTH
//                overflow, underflow - sticky rejected-push / rejected-pop flags
//                display             - {select[7:0], dp, seg[6:0]}, all active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_param_scan #(
    parameter int WIDTH    = 4,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL = 1,
    parameter int SCAN_DIV = 10000,
    parameter int EDGE     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_in,
    input  logic              en_out,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic [15:0]       display
);

    localparam int   c_DEPTH  = 1 << ADDR_W;
    localparam int   c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic c_EDGE   = (EDGE != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    r_mem [c_DEPTH];
    logic [ADDR_W-1:0]   r_head;
    logic [ADDR_W-1:0]   r_tail;
    logic [ADDR_W:0]     r_count;
    logic [WIDTH-1:0]    r_out;
    logic                r_out_valid;
    logic                r_ovf;
    logic                r_udf;
    logic                r_prev_in;
    logic                r_prev_out;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [2:0]          r_digit;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic w_req_in;
    logic w_req_out;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // In level mode c_EDGE masks the previous-sample term away.
    assign w_req_in  = en_in  & ~(c_EDGE & r_prev_in);
    assign w_req_out = en_out & ~(c_EDGE & r_prev_out);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (ADDR_W+1)'(c_DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // simultaneous push. An empty FIFO never bypasses push data to out.
    assign w_pop  = w_req_out & ~w_empty;
    assign w_push = w_req_in & (~w_full | w_pop);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // Capture the current button levels so a button held through
            // reset does not look like a fresh edge afterwards.
            r_prev_in   <= en_in;
            r_prev_out  <= en_out;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            r_prev_in   <= en_in;
            r_prev_out  <= en_out;
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_out  <= r_mem[r_head];
                r_head <= r_head + ADDR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (ADDR_W+1)'(1);
            end
            // A new error event in the same cycle as clear_err wins.
            r_ovf <= (r_ovf & ~clear_err) | (w_req_in & ~w_push);
            r_udf <= (r_udf & ~clear_err) | (w_req_out & w_empty);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_tail] <= in;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else if (r_scan_cnt == c_SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

    logic [ADDR_W-1:0] w_disp_idx;
    logic [3:0]        w_nib;
    logic              w_digit_used;
    logic [6:0]        w_font;
    logic [6:0]        w_seg;
    logic              w_dp;
    logic [7:0]        w_select;

    // Digit d shows the d-th oldest entry; index wraps modulo DEPTH.
    assign w_disp_idx   = r_head + ADDR_W'(r_digit);
    assign w_nib        = 4'(r_mem[w_disp_idx]);
    assign w_digit_used = (32'(r_digit) < 32'(r_count));

    always_comb begin
        w_font = 7'h7F;
        case (w_nib)
            4'h0: w_font = 7'b0000001;
            4'h1: w_font = 7'b1001111;
            4'h2: w_font = 7'b0010010;
            4'h3: w_font = 7'b0000110;
            4'h4: w_font = 7'b1001100;
            4'h5: w_font = 7'b0100100;
            4'h6: w_font = 7'b0100000;
            4'h7: w_font = 7'b0001111;
            4'h8: w_font = 7'b0000000;
            4'h9: w_font = 7'b0000100;
            4'hA: w_font = 7'b0001000;
            4'hB: w_font = 7'b1100000;
            4'hC: w_font = 7'b0110001;
            4'hD: w_font = 7'b1000010;
            4'hE: w_font = 7'b0110000;
            4'hF: w_font = 7'b0111000;
            default: w_font = 7'h7F;
        endcase
    end

    assign w_seg    = w_digit_used ? w_font : 7'h7F;
    assign w_dp     = ~((r_digit == 3'd0) & ~w_empty);
    assign w_select = ~(8'b1 << r_digit);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out          = r_out;
    assign out_valid    = r_out_valid;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (int'(r_count) <= AE_LEVEL);
    assign almost_full  = (int'(r_count) >= AF_LEVEL);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    assign display      = {w_select, w_dp, w_seg};

endmodule
`default_nettype wire

// File: tb/tb_fifo_param_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_param_scan
//  Description : Directed self-checking bench for fifo_param_scan. One
//                edge-triggered instance (dut) and one level-triggered
//                instance (dut_lvl) share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en_in = 1'b0, en_out = 1'b0, clear_err = 1'b0;
    logic [3:0]  din = 4'h0;
    logic [3:0]  out;
    logic        out_valid, empty, full, almost_empty, almost_full;
    logic [3:0]  count;
    logic        overflow, underflow;
    logic [15:0] display;

    logic        en_in1 = 1'b0, en_out1 = 1'b0;
    logic [3:0]  din1 = 4'h0;
    logic [3:0]  out1;
    logic        out_valid1, empty1, full1, ae1, af1, ovf1, udf1;
    logic [3:0]  count1;
    logic [15:0] display1;

    int errors = 0;
    int checks = 0;
    int vp;

    always #5 clock = ~clock;

    fifo_param_scan #(.WIDTH(4), .ADDR_W(3), .SCAN_DIV(4), .EDGE(1)) dut (
        .clock(clock), .reset(reset), .en_in(en_in), .en_out(en_out),
        .in(din), .clear_err(clear_err), .out(out), .out_valid(out_valid),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .display(display)
    );

    fifo_param_scan #(.WIDTH(4), .ADDR_W(3), .SCAN_DIV(4), .EDGE(0)) dut_lvl (
        .clock(clock), .reset(reset), .en_in(en_in1), .en_out(en_out1),
        .in(din1), .clear_err(1'b0), .out(out1), .out_valid(out_valid1),
        .empty(empty1), .full(full1), .almost_empty(ae1),
        .almost_full(af1), .count(count1), .overflow(ovf1),
        .underflow(udf1), .display(display1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] v);
        din   = v;
        en_in = 1'b1;
        tick();
        en_in = 1'b0;
        tick();
    endtask

    // Pop one entry and check the value and the strobe shape.
    task automatic pop_chk(input string tag, input logic [3:0] v);
        en_out = 1'b1;
        tick();
        chk({tag, "_out"}, 32'(out), 32'(v));
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        vp += int'(out_valid);
        en_out = 1'b0;
        tick();
        vp += int'(out_valid);
    endtask

    // Wait (bounded) for the scan to select digit d, then compare display.
    task automatic show_digit(input string tag, input int d, input logic [15:0] exp);
        logic [7:0] sel;
        sel = ~(8'b1 << d);
        for (int n = 0; n < 40; n++) begin
            if (display[15:8] == sel) break;
            tick();
        end
        chk(tag, 32'(display), 32'(exp));
    endtask

    initial begin
        int prev_hit;
        int t_first;
        int period;

        // ---- 1: reset state and three pushes ----
        do_reset();
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_empty",  32'(empty), 32'd1);
        chk("rst_ae",     32'(almost_empty), 32'd1);
        chk("rst_full",   32'(full), 32'd0);
        chk("rst_out",    32'(out), 32'd0);
        chk("rst_vld",    32'(out_valid), 32'd0);
        chk("rst_ovf",    32'(overflow), 32'd0);
        chk("rst_udf",    32'(underflow), 32'd0);
        push(4'h1);
        push(4'h2);
        push(4'h3);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_empty", 32'(empty), 32'd0);
        chk("t1_ae",    32'(almost_empty), 32'd0);
        show_digit("t1_dig0", 0, 16'hFE4F);
        show_digit("t1_dig1", 1, 16'hFD92);
        show_digit("t1_dig2", 2, 16'hFB86);
        show_digit("t1_dig3", 3, 16'hF7FF);
        show_digit("t1_dig7", 7, 16'h7FFF);

        // ---- 2: fill, overflow, drain ----
        do_reset();
        for (int i = 0; i < 7; i++) push(4'(i));
        chk("t2_af7",   32'(almost_full), 32'd1);
        chk("t2_full7", 32'(full), 32'd0);
        push(4'h7);
        chk("t2_full",  32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd8);
        chk("t2_ovf0",  32'(overflow), 32'd0);
        push(4'h9);
        chk("t2_ovf",   32'(overflow), 32'd1);
        chk("t2_cnt9",  32'(count), 32'd8);
        vp = 0;
        for (int i = 0; i < 8; i++) pop_chk("t2_pop", 4'(i));
        chk("t2_vpulses", 32'(vp), 32'd8);
        chk("t2_empty",   32'(empty), 32'd1);
        chk("t2_ovf_stk", 32'(overflow), 32'd1);

        // ---- 3: simultaneous push+pop while full ----
        do_reset();
        for (int i = 0; i < 8; i++) push(4'(8 + i));
        din    = 4'h5;
        en_in  = 1'b1;
        en_out = 1'b1;
        tick();
        chk("t3_count", 32'(count), 32'd8);
        chk("t3_out",   32'(out), 32'h8);
        chk("t3_ovf",   32'(overflow), 32'd0);
        chk("t3_full",  32'(full), 32'd1);
        en_in  = 1'b0;
        en_out = 1'b0;
        tick();
        vp = 0;
        for (int i = 0; i < 7; i++) pop_chk("t3_pop", 4'(9 + i));
        pop_chk("t3_new", 4'h5);
        chk("t3_empty", 32'(empty), 32'd1);

        // ---- 4: underflow and clear priority ----
        en_out = 1'b1;
        tick();
        chk("t4_udf",     32'(underflow), 32'd1);
        chk("t4_out",     32'(out), 32'h5);
        chk("t4_vld",     32'(out_valid), 32'd0);
        en_out = 1'b0;
        tick();
        clear_err = 1'b1;
        en_out    = 1'b1;
        tick();
        chk("t4_setwins", 32'(underflow), 32'd1);
        clear_err = 1'b0;
        en_out    = 1'b0;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t4_clear",   32'(underflow), 32'd0);

        // ---- 5: held buttons, reset while held, level mode ----
        do_reset();
        din   = 4'h7;
        en_in = 1'b1;
        repeat (20) tick();
        chk("t5_hold1", 32'(count), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t5_rsthold", 32'(count), 32'd0);
        en_in = 1'b0;
        tick();
        din1   = 4'h3;
        en_in1 = 1'b1;
        repeat (3) tick();
        en_in1 = 1'b0;
        tick();
        chk("t5_lvl3", 32'(count1), 32'd3);
        en_out1 = 1'b1;
        repeat (2) tick();
        en_out1 = 1'b0;
        chk("t5_lvlpop", 32'(count1), 32'd1);
        chk("t5_lvlout", 32'(out1), 32'h3);

        // ---- 6: pointer wrap and scan period ----
        do_reset();
        push(4'h0);
        push(4'h1);
        push(4'h2);
        vp = 0;
        for (int i = 3; i < 23; i++) begin
            push(4'(i));
            pop_chk("t6_pop", 4'(i - 3));
        end
        chk("t6_count", 32'(count), 32'd3);
        // oldest remaining are 20,21,22 -> 4,5,6
        show_digit("t6_dig0", 0, 16'hFE4C);

        prev_hit = (display[15:8] == 8'hFE) ? 1 : 0;
        t_first  = -1;
        period   = -1;
        for (int n = 0; n < 120; n++) begin
            tick();
            if (display[15:8] == 8'hFE && prev_hit == 0) begin
                if (t_first < 0) begin
                    t_first = n;
                end else begin
                    period = n - t_first;
                    break;
                end
            end
            prev_hit = (display[15:8] == 8'hFE) ? 1 : 0;
        end
        chk("t6_scan_period", 32'(period), 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
